pong_game_ctrl: RTL and testbench

//  Match controller for the pong datapath. Consumes the ball block's score flags
//  and the player buttons, and drives that block's start, animate and reset inputs.

---
 rtl/pong_pkg.sv | 25 ++
 rtl/pong_game_if.sv | 37 +++
 rtl/pong_edge_rise.sv | 27 ++
 rtl/pong_game_ctrl.sv | 150 +++++++++++++++
 tb/tb_pong_game_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_pkg
// Description : Shared types and constants for the pong match controller.
// Revision    : 1.0
// ============================================================================
package pong_pkg;

    localparam int PTS_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SERVE  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_PAUSED = 3'd3,
        ST_POINT  = 3'd4,
        ST_OVER   = 3'd5
    } pong_state_e;

    localparam logic [1:0] WINNER_NONE  = 2'b00;
    localparam logic [1:0] WINNER_LEFT  = 2'b01;
    localparam logic [1:0] WINNER_RIGHT = 2'b10;

endpackage
`default_nettype wire

// File: rtl/pong_game_if.sv
`default_nettype none
// ============================================================================
// Module      : pong_game_if
// Description : Signals between the match controller and the ball/button side.
// Revision    : 1.0
// ============================================================================
interface pong_game_if;
    import pong_pkg::*;

    logic             in_ani_stb;
    logic             in_left_score;
    logic             in_right_score;
    logic             in_btn_start;
    logic             in_btn_pause;
    logic             out_start;
    logic             out_animate;
    logic             out_ball_reset;
    logic [PTS_W-1:0] out_left_pts;
    logic [PTS_W-1:0] out_right_pts;
    logic [1:0]       out_winner;
    logic [2:0]       out_state;

    // master is the controller side
    modport master (
        input  in_ani_stb, in_left_score, in_right_score, in_btn_start, in_btn_pause,
        output out_start, out_animate, out_ball_reset, out_left_pts, out_right_pts,
               out_winner, out_state
    );

    modport slave (
        output in_ani_stb, in_left_score, in_right_score, in_btn_start, in_btn_pause,
        input  out_start, out_animate, out_ball_reset, out_left_pts, out_right_pts,
               out_winner, out_state
    );

endinterface
`default_nettype wire

// File: rtl/pong_edge_rise.sv
`default_nettype none
// ============================================================================
// Module      : pong_edge_rise
// Description : Registered rising-edge pulse for a level score flag.
// Revision    : 1.0
// ============================================================================
module pong_edge_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic flag,
    output logic rise
);

    logic r_flag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_q <= 1'b0;
            rise     <= 1'b0;
        end else begin
            r_flag_q <= flag;
            rise     <= flag & ~r_flag_q;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pong_game_ctrl
// Description : Pong match FSM: serve delay, points, pause and winner.
// Revision    : 1.0
// ============================================================================
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60
) (
    input  logic        in_clock,
    input  logic        in_reset_n,
    pong_game_if.master bus
);

    localparam logic [PTS_W-1:0] C_WIN        = PTS_W'(WIN_SCORE);
    localparam logic [7:0]       C_SERVE_LAST = 8'(SERVE_FRAMES - 1);

    logic             r_rst_meta;
    logic             r_rst_sync;
    logic             w_left_rise;
    logic             w_right_rise;
    pong_state_e      r_state;
    logic [7:0]       r_serve_cnt;
    logic [PTS_W-1:0] r_left_pts;
    logic [PTS_W-1:0] r_right_pts;
    logic [1:0]       r_winner;
    logic             r_start;
    logic             r_animate;
    logic             r_ball_reset;

    // Assert immediately, release only after two clean clock edges
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    pong_edge_rise u_left_rise (
        .clk   (in_clock),
        .rst_n (r_rst_sync),
        .flag  (bus.in_left_score),
        .rise  (w_left_rise)
    );

    pong_edge_rise u_right_rise (
        .clk   (in_clock),
        .rst_n (r_rst_sync),
        .flag  (bus.in_right_score),
        .rise  (w_right_rise)
    );

    always_ff @(posedge in_clock or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_state      <= ST_IDLE;
            r_serve_cnt  <= 8'd0;
            r_left_pts   <= '0;
            r_right_pts  <= '0;
            r_winner     <= WINNER_NONE;
            r_start      <= 1'b0;
            r_animate    <= 1'b0;
            r_ball_reset <= 1'b0;
        end else begin
            r_start      <= 1'b0;
            r_ball_reset <= 1'b0;
            case (r_state)
                ST_IDLE, ST_OVER: begin
                    if (bus.in_btn_start) begin
                        r_left_pts   <= '0;
                        r_right_pts  <= '0;
                        r_winner     <= WINNER_NONE;
                        r_ball_reset <= 1'b1;
                        r_state      <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (bus.in_ani_stb) begin
                        if (r_serve_cnt == C_SERVE_LAST) begin
                            r_serve_cnt <= 8'd0;
                            r_start     <= 1'b1;
                            r_animate   <= 1'b1;
                            r_state     <= ST_PLAY;
                        end else begin
                            r_serve_cnt <= r_serve_cnt + 8'd1;
                        end
                    end
                end
                ST_PLAY: begin
                    // A simultaneous double score is a re-serve with no point
                    if (w_left_rise && w_right_rise) begin
                        r_animate <= 1'b0;
                        r_state   <= ST_POINT;
                    end else if (w_left_rise) begin
                        if (r_left_pts != C_WIN) begin
                            r_left_pts <= r_left_pts + 1'b1;
                        end
                        r_animate <= 1'b0;
                        r_state   <= ST_POINT;
                    end else if (w_right_rise) begin
                        if (r_right_pts != C_WIN) begin
                            r_right_pts <= r_right_pts + 1'b1;
                        end
                        r_animate <= 1'b0;
                        r_state   <= ST_POINT;
                    end else if (bus.in_btn_pause) begin
                        r_animate <= 1'b0;
                        r_state   <= ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (bus.in_btn_pause) begin
                        r_animate <= 1'b1;
                        r_state   <= ST_PLAY;
                    end
                end
                ST_POINT: begin
                    if (r_left_pts == C_WIN) begin
                        r_winner <= WINNER_LEFT;
                        r_state  <= ST_OVER;
                    end else if (r_right_pts == C_WIN) begin
                        r_winner <= WINNER_RIGHT;
                        r_state  <= ST_OVER;
                    end else begin
                        r_state <= ST_SERVE;
                    end
                end
                default: begin
                    r_animate <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.out_start      = r_start;
    assign bus.out_animate    = r_animate;
    assign bus.out_ball_reset = r_ball_reset;
    assign bus.out_left_pts   = r_left_pts;
    assign bus.out_right_pts  = r_right_pts;
    assign bus.out_winner     = r_winner;
    assign bus.out_state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_game_ctrl
// Description : Directed match scenarios plus random play against a match model.
// Revision    : 1.0
// ============================================================================
module tb_pong_game_ctrl;

    localparam int WIN    = 4;
    localparam int FRAMES = 3;

    localparam int M_IDLE   = 0;
    localparam int M_SERVE  = 1;
    localparam int M_PLAY   = 2;
    localparam int M_PAUSED = 3;
    localparam int M_POINT  = 4;
    localparam int M_OVER   = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pong_game_if bus ();

    pong_game_ctrl #(
        .WIN_SCORE    (WIN),
        .SERVE_FRAMES (FRAMES)
    ) dut (
        .in_clock   (clk),
        .in_reset_n (rst_n),
        .bus        (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic fl = 1'b0;
    logic fr = 1'b0;

    // Match model: phase, scores, winner, strobe tally, flag sample history
    int   m_mode, m_lp, m_rp, m_win, m_strobes, m_dead;
    logic m_start, m_anim, m_breset;
    logic [1:0] hl, hr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_lp = 0; m_rp = 0; m_win = 0; m_strobes = 0; m_dead = 0;
        m_start = 1'b0; m_anim = 1'b0; m_breset = 1'b0;
        hl = 2'b00; hr = 2'b00;
    endtask

    task automatic model_step(input logic stb, input logic st, input logic pz);
        logic ev_l, ev_r;
        if (!rst_n) return;
        if (m_dead > 0) begin
            m_dead--;
            return;
        end
        ev_l = hl[0] & ~hl[1];
        ev_r = hr[0] & ~hr[1];
        hl = {hl[0], fl};
        hr = {hr[0], fr};
        m_start  = 1'b0;
        m_breset = 1'b0;
        case (m_mode)
            M_IDLE, M_OVER: if (st) begin
                m_lp = 0; m_rp = 0; m_win = 0; m_breset = 1'b1; m_mode = M_SERVE;
            end
            M_SERVE: if (stb) begin
                m_strobes++;
                if (m_strobes == FRAMES) begin
                    m_strobes = 0; m_start = 1'b1; m_mode = M_PLAY;
                end
            end
            M_PLAY: begin
                if (ev_l && ev_r) m_mode = M_POINT;
                else if (ev_l) begin
                    if (m_lp < WIN) m_lp++;
                    m_mode = M_POINT;
                end else if (ev_r) begin
                    if (m_rp < WIN) m_rp++;
                    m_mode = M_POINT;
                end else if (pz) m_mode = M_PAUSED;
            end
            M_PAUSED: if (pz) m_mode = M_PLAY;
            M_POINT: begin
                if (m_lp == WIN) begin m_win = 1; m_mode = M_OVER; end
                else if (m_rp == WIN) begin m_win = 2; m_mode = M_OVER; end
                else m_mode = M_SERVE;
            end
            default: m_mode = M_IDLE;
        endcase
        m_anim = (m_mode == M_PLAY);
    endtask

    task automatic compare_all();
        check("state",      32'(bus.out_state),      32'(m_mode));
        check("animate",    32'(bus.out_animate),    32'(m_anim));
        check("start",      32'(bus.out_start),      32'(m_start));
        check("ball_reset", 32'(bus.out_ball_reset), 32'(m_breset));
        check("left_pts",   32'(bus.out_left_pts),   32'(m_lp));
        check("right_pts",  32'(bus.out_right_pts),  32'(m_rp));
        check("winner",     32'(bus.out_winner),     32'(m_win));
    endtask

    task automatic tick(input logic stb, input logic st, input logic pz);
        bus.in_ani_stb     = stb;
        bus.in_btn_start   = st;
        bus.in_btn_pause   = pz;
        bus.in_left_score  = fl;
        bus.in_right_score = fr;
        @(posedge clk);
        model_step(stb, st, pz);
        #1;
        compare_all();
    endtask

    task automatic serve();
        for (int i = 0; i < 40 && m_mode != M_PLAY; i++) tick(1'b1, 1'b0, 1'b0);
        check("serve_reaches_play", 32'(bus.out_state), 32'(M_PLAY));
    endtask

    task automatic score(input logic l, input logic r);
        fl = l;
        fr = r;
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        fl = 1'b0;
        fr = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.in_ani_stb = 1'b0; bus.in_btn_start = 1'b0; bus.in_btn_pause = 1'b0;
        bus.in_left_score = 1'b0; bus.in_right_score = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
        m_dead = 2;
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        check("post_reset_idle", 32'(bus.out_state), 32'(M_IDLE));

        // New game: ball reset pulse, serve after three strobes
        tick(1'b0, 1'b1, 1'b0);
        check("t2_ball_reset", 32'(bus.out_ball_reset), 32'd1);
        check("t2_serve", 32'(bus.out_state), 32'(M_SERVE));
        tick(1'b0, 1'b0, 1'b0);
        check("t2_ball_reset_1cyc", 32'(bus.out_ball_reset), 32'd0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check("t2_no_early_start", 32'(bus.out_start), 32'd0);
        tick(1'b1, 1'b0, 1'b0);
        check("t2_start", 32'(bus.out_start), 32'd1);
        check("t2_animate", 32'(bus.out_animate), 32'd1);
        tick(1'b0, 1'b0, 1'b0);
        check("t2_start_1cyc", 32'(bus.out_start), 32'd0);

        // Held left flag scores once
        fl = 1'b1;
        repeat (50) tick(1'b0, 1'b0, 1'b0);
        check("t3_left_once", 32'(bus.out_left_pts), 32'd1);
        check("t3_serve", 32'(bus.out_state), 32'(M_SERVE));
        fl = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        serve();
        check("t3_restart", 32'(bus.out_start), 32'd1);

        // Simultaneous scores: re-serve, no point
        score(1'b1, 1'b1);
        check("t4_left", 32'(bus.out_left_pts), 32'd1);
        check("t4_right", 32'(bus.out_right_pts), 32'd0);
        check("t4_serve", 32'(bus.out_state), 32'(M_SERVE));
        serve();

        // Pause masks a score
        tick(1'b0, 1'b0, 1'b1);
        check("t5_paused", 32'(bus.out_state), 32'(M_PAUSED));
        check("t5_anim_off", 32'(bus.out_animate), 32'd0);
        fr = 1'b1;
        repeat (4) tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        check("t5_resumed", 32'(bus.out_state), 32'(M_PLAY));
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        check("t5_right_none", 32'(bus.out_right_pts), 32'd0);
        fr = 1'b0;
        tick(1'b0, 1'b0, 1'b0);

        // Build 3/2 then reset in the middle of play
        score(1'b1, 1'b0); serve();
        score(1'b1, 1'b0); serve();
        score(1'b0, 1'b1); serve();
        score(1'b0, 1'b1); serve();
        check("t1_left3", 32'(bus.out_left_pts), 32'd3);
        check("t1_right2", 32'(bus.out_right_pts), 32'd2);
        tick(1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("t1_async_pts", 32'(bus.out_left_pts), 32'd0);
        repeat (2) tick(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        m_dead = 2;
        repeat (3) begin
            tick(1'b0, 1'b0, 1'b0);
            check("t1_no_pulse", 32'({bus.out_start, bus.out_ball_reset}), 32'd0);
        end

        // Right wins the match, then a new game clears it
        tick(1'b0, 1'b1, 1'b0);
        serve();
        for (int k = 0; k < WIN; k++) begin
            score(1'b0, 1'b1);
            if (k < WIN - 1) serve();
        end
        check("t6_winner", 32'(bus.out_winner), 32'd2);
        check("t6_over", 32'(bus.out_state), 32'(M_OVER));
        check("t6_anim", 32'(bus.out_animate), 32'd0);
        tick(1'b0, 1'b1, 1'b0);
        check("t6_clear_pts", 32'({bus.out_left_pts, bus.out_right_pts}), 32'd0);
        check("t6_clear_win", 32'(bus.out_winner), 32'd0);

        // Random play
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) fl = ~fl;
            if ($urandom_range(0, 7) == 0) fr = ~fr;
            tick(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 29) == 0),
                 1'($urandom_range(0, 39) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
